// File: rtl/ext_adc_scan.sv
// Periodic multi-channel sensor scanner driving an external ADC handshake.
// Stores per-channel samples and flags channels whose value moved past a threshold.
module ext_adc_scan #(
    parameter int DataWidth    = 16,
    parameter int NumChannels  = 4,
    parameter int ChanSelWidth = 2,
    parameter int CounterWidth = 16
) (
    input  logic                             Clk_i,
    input  logic                             Reset_i,
    input  logic                             Enable_i,
    input  logic [NumChannels-1:0]           ChannelMask_i,
    input  logic [CounterWidth-1:0]          PeriodCounterPreset_i,
    input  logic [CounterWidth-1:0]          TimeoutPreset_i,
    input  logic [DataWidth-1:0]             Threshold_i,
    output logic                             SensorPower_o,
    output logic                             SensorStart_o,
    input  logic                             SensorReady_i,
    output logic                             AdcStart_o,
    output logic [ChanSelWidth-1:0]          AdcChannel_o,
    input  logic                             AdcDone_i,
    input  logic [DataWidth-1:0]             AdcValue_i,
    output logic [NumChannels*DataWidth-1:0] SensorValues_o,
    output logic [NumChannels-1:0]           ChangedMask_o,
    output logic                             Timeout_o,
    output logic                             CpuIntr_o,
    input  logic                             IntrAck_i
);

    typedef enum logic [2:0] {
        S_DISABLED,
        S_IDLE,
        S_POWERUP,
        S_CONVERT,
        S_SETTLE
    } state_e;

    state_e                                state_q;
    logic [CounterWidth-1:0]               period_q;
    logic [CounterWidth-1:0]               tmo_q;
    logic [NumChannels-1:0]                scan_mask_q;
    logic [NumChannels-1:0]                valid_q;
    logic [NumChannels-1:0]                changed_q;
    logic [NumChannels-1:0]                changed_d;
    logic [ChanSelWidth-1:0]               chan_q;
    logic [ChanSelWidth-1:0]               adc_chan_q;
    logic [ChanSelWidth-1:0]               first_chan;
    logic [ChanSelWidth-1:0]               next_chan;
    logic                                  has_next;
    logic [NumChannels-1:0][DataWidth-1:0] stored_q;
    logic                                  power_q;
    logic                                  start_q;
    logic                                  adc_start_q;
    logic                                  tmo_flag_q;
    logic                                  intr_q;
    logic [DataWidth-1:0]                  cur_val;
    logic [DataWidth-1:0]                  abs_diff;
    logic signed [DataWidth:0]             diff;
    logic signed [DataWidth:0]             diff_neg;
    logic                                  do_store;
    logic                                  sample;
    logic                                  tmo_hit;

    assign SensorPower_o  = power_q;
    assign SensorStart_o  = start_q;
    assign AdcStart_o     = adc_start_q;
    assign AdcChannel_o   = adc_chan_q;
    assign SensorValues_o = stored_q;
    assign ChangedMask_o  = changed_q;
    assign Timeout_o      = tmo_flag_q;
    assign CpuIntr_o      = intr_q;

    // Change detection: one extra bit keeps the difference from wrapping
    always_comb begin
        cur_val  = stored_q[chan_q];
        diff     = $signed({1'b0, AdcValue_i}) - $signed({1'b0, cur_val});
        diff_neg = -diff;
        abs_diff = diff[DataWidth] ? diff_neg[DataWidth-1:0] : diff[DataWidth-1:0];
        do_store = !valid_q[chan_q] || (abs_diff > Threshold_i);
        sample   = Enable_i && (state_q == S_CONVERT) && AdcDone_i;
        tmo_hit  = (TimeoutPreset_i != '0) && (tmo_q == '0);
    end

    // Lowest requested channel and next higher channel still in the scan
    always_comb begin
        first_chan = '0;
        next_chan  = '0;
        has_next   = 1'b0;
        for (int i = NumChannels - 1; i >= 0; i--) begin
            if (ChannelMask_i[i]) first_chan = ChanSelWidth'(i);
            if (scan_mask_q[i] && (ChanSelWidth'(i) > chan_q)) begin
                next_chan = ChanSelWidth'(i);
                has_next  = 1'b1;
            end
        end
    end

    // Sticky change flags: ack clears, a same-cycle update still lands
    always_comb begin
        changed_d = IntrAck_i ? '0 : changed_q;
        if (sample && do_store) changed_d[chan_q] = 1'b1;
    end

    // Scan sequencer with registered handshake outputs and flags
    always_ff @(posedge Clk_i or posedge Reset_i) begin
        if (Reset_i) begin
            state_q     <= S_DISABLED;
            period_q    <= '0;
            tmo_q       <= '0;
            scan_mask_q <= '0;
            valid_q     <= '0;
            changed_q   <= '0;
            chan_q      <= '0;
            adc_chan_q  <= '0;
            stored_q    <= '0;
            power_q     <= 1'b0;
            start_q     <= 1'b0;
            adc_start_q <= 1'b0;
            tmo_flag_q  <= 1'b0;
            intr_q      <= 1'b0;
        end else begin
            changed_q <= changed_d;
            if (IntrAck_i) begin
                intr_q     <= 1'b0;
                tmo_flag_q <= 1'b0;
            end
            if (!Enable_i) begin
                state_q     <= S_DISABLED;
                period_q    <= PeriodCounterPreset_i;
                tmo_q       <= '0;
                valid_q     <= '0;
                power_q     <= 1'b0;
                start_q     <= 1'b0;
                adc_start_q <= 1'b0;
                adc_chan_q  <= '0;
            end else begin
                case (state_q)
                    S_DISABLED: begin
                        period_q <= PeriodCounterPreset_i;
                        state_q  <= S_IDLE;
                    end
                    S_IDLE: begin
                        if (period_q == '0) begin
                            period_q <= PeriodCounterPreset_i;
                            if (ChannelMask_i != '0) begin
                                state_q     <= S_POWERUP;
                                scan_mask_q <= ChannelMask_i;
                                chan_q      <= first_chan;
                                tmo_q       <= TimeoutPreset_i;
                                power_q     <= 1'b1;
                                start_q     <= 1'b1;
                            end
                        end else begin
                            period_q <= period_q - CounterWidth'(1);
                        end
                    end
                    S_POWERUP: begin
                        if (SensorReady_i) begin
                            state_q     <= S_CONVERT;
                            tmo_q       <= TimeoutPreset_i;
                            adc_start_q <= 1'b1;
                            adc_chan_q  <= chan_q;
                        end else if (tmo_hit) begin
                            state_q    <= S_IDLE;
                            power_q    <= 1'b0;
                            start_q    <= 1'b0;
                            tmo_flag_q <= 1'b1;
                            intr_q     <= 1'b1;
                        end else if (tmo_q != '0) begin
                            tmo_q <= tmo_q - CounterWidth'(1);
                        end
                    end
                    S_CONVERT: begin
                        if (AdcDone_i) begin
                            if (do_store) stored_q[chan_q] <= AdcValue_i;
                            valid_q[chan_q] <= 1'b1;
                            adc_start_q     <= 1'b0;
                            if (has_next) begin
                                state_q <= S_SETTLE;
                                chan_q  <= next_chan;
                            end else begin
                                state_q    <= S_IDLE;
                                power_q    <= 1'b0;
                                start_q    <= 1'b0;
                                adc_chan_q <= '0;
                                if (changed_d != '0) intr_q <= 1'b1;
                            end
                        end else if (tmo_hit) begin
                            state_q     <= S_IDLE;
                            power_q     <= 1'b0;
                            start_q     <= 1'b0;
                            adc_start_q <= 1'b0;
                            adc_chan_q  <= '0;
                            tmo_flag_q  <= 1'b1;
                            intr_q      <= 1'b1;
                        end else if (tmo_q != '0) begin
                            tmo_q <= tmo_q - CounterWidth'(1);
                        end
                    end
                    S_SETTLE: begin
                        state_q     <= S_CONVERT;
                        tmo_q       <= TimeoutPreset_i;
                        adc_start_q <= 1'b1;
                        adc_chan_q  <= chan_q;
                    end
                    default: begin
                        state_q <= S_DISABLED;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ext_adc_scan.sv
// Directed bench for ext_adc_scan: scan sequencing, change detection,
// timeouts, enable drop and asynchronous reset.
module tb_ext_adc_scan;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  mask;
    logic [15:0] period;
    logic [15:0] tmo;
    logic [15:0] thr;
    logic        power;
    logic        start;
    logic        ready;
    logic        adc_start;
    logic [1:0]  adc_chan;
    logic        adc_done;
    logic [15:0] adc_val;
    logic [63:0] values;
    logic [3:0]  changed;
    logic        timeout;
    logic        intr;
    logic        ack;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ext_adc_scan dut (
        .Clk_i                 (clk),
        .Reset_i               (rst),
        .Enable_i              (en),
        .ChannelMask_i         (mask),
        .PeriodCounterPreset_i (period),
        .TimeoutPreset_i       (tmo),
        .Threshold_i           (thr),
        .SensorPower_o         (power),
        .SensorStart_o         (start),
        .SensorReady_i         (ready),
        .AdcStart_o            (adc_start),
        .AdcChannel_o          (adc_chan),
        .AdcDone_i             (adc_done),
        .AdcValue_i            (adc_val),
        .SensorValues_o        (values),
        .ChangedMask_o         (changed),
        .Timeout_o             (timeout),
        .CpuIntr_o             (intr),
        .IntrAck_i             (ack)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_power(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (power) break;
            @(negedge clk);
        end
        chk("wait_power", power, 1);
    endtask

    // One single-channel scan ending in IDLE
    task automatic scan1(input logic [15:0] v);
        wait_power(20);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("scan_adc_start", adc_start, 1);
        adc_done = 1'b1;
        adc_val  = v;
        @(negedge clk);
        adc_done = 1'b0;
        chk("scan_end_power", power, 0);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_intr", intr, 0);
        chk("ack_changed", changed, 0);
        chk("ack_timeout", timeout, 0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mask = '0; period = '0; tmo = '0; thr = '0;
        ready = 1'b0; adc_done = 1'b0; adc_val = '0; ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_power", power, 0);
        chk("rst_values", values, 0);
        chk("rst_intr", intr, 0);
        rst = 1'b0;

        // Two-channel scan, first samples always stored
        period = 16'd3; mask = 4'b0101; en = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_4_cycles", power, 0);
        @(negedge clk);
        chk("powerup_power", power, 1);
        chk("powerup_start", start, 1);
        @(negedge clk);
        chk("powerup_no_adc", adc_start, 0);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("conv0_start", adc_start, 1);
        chk("conv0_chan", adc_chan, 0);
        repeat (2) @(negedge clk);
        chk("conv0_held", adc_start, 1);
        adc_done = 1'b1; adc_val = 16'h1234;
        @(negedge clk);
        adc_done = 1'b0;
        chk("settle_adc", adc_start, 0);
        chk("settle_power", power, 1);
        chk("ch0_first", values[15:0], 16'h1234);
        chk("settle_changed", changed, 4'b0001);
        @(negedge clk);
        chk("conv2_start", adc_start, 1);
        chk("conv2_chan", adc_chan, 2);
        adc_done = 1'b1; adc_val = 16'h0042;
        @(negedge clk);
        adc_done = 1'b0;
        chk("end_start", start, 0);
        chk("ch2_first", values[47:32], 16'h0042);
        chk("end_changed", changed, 4'b0101);
        chk("end_intr", intr, 1);
        mask = 4'b0001;
        do_ack();

        // Threshold is strict
        scan1(16'd100);
        chk("ch0_100", values[15:0], 16'd100);
        do_ack();
        thr = 16'd10;
        scan1(16'd110);
        chk("thr_eq_nostore", values[15:0], 16'd100);
        chk("thr_eq_changed", changed, 0);
        chk("thr_eq_intr", intr, 0);
        scan1(16'd111);
        chk("thr_gt_store", values[15:0], 16'd111);
        chk("thr_gt_changed", changed, 4'b0001);
        chk("thr_gt_intr", intr, 1);
        do_ack();

        // Negative difference without wrap
        thr = 16'd0;
        scan1(16'd200);
        do_ack();
        thr = 16'd100;
        scan1(16'd5);
        chk("neg_diff_store", values[15:0], 16'd5);
        chk("neg_diff_changed", changed, 4'b0001);
        do_ack();
        scan1(16'd90);
        chk("small_diff_keep", values[15:0], 16'd5);
        chk("small_diff_intr", intr, 0);

        // Timeout waiting for sensor ready
        tmo = 16'd5;
        wait_power(20);
        repeat (5) @(negedge clk);
        chk("pu_tmo_early", timeout, 0);
        chk("pu_tmo_early_pwr", power, 1);
        @(negedge clk);
        chk("pu_tmo_flag", timeout, 1);
        chk("pu_tmo_intr", intr, 1);
        chk("pu_tmo_power", power, 0);
        do_ack();

        // Timeout waiting for conversion
        wait_power(20);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        repeat (5) @(negedge clk);
        chk("cv_tmo_early", adc_start, 1);
        @(negedge clk);
        chk("cv_tmo_adc", adc_start, 0);
        chk("cv_tmo_flag", timeout, 1);
        chk("cv_tmo_intr", intr, 1);
        chk("cv_tmo_nostore", values[15:0], 16'd5);
        tmo = 16'd0;
        do_ack();

        // Enable drop mid-conversion, then fresh first sample
        wait_power(20);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("dis_pre_adc", adc_start, 1);
        en = 1'b0;
        @(negedge clk);
        chk("dis_power", power, 0);
        chk("dis_start", start, 0);
        chk("dis_adc", adc_start, 0);
        chk("dis_keep", values[15:0], 16'd5);
        en = 1'b1;
        scan1(16'd6);
        chk("reen_store", values[15:0], 16'd6);
        chk("reen_changed", changed, 4'b0001);
        do_ack();

        // Asynchronous reset mid-conversion
        wait_power(20);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        chk("rst_pre_adc", adc_start, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_adc", adc_start, 0);
        chk("arst_power", power, 0);
        chk("arst_values", values, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("restart_idle", power, 0);
        @(negedge clk);
        chk("restart_power", power, 1);
        en = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
